// File: rtl/delay_line_ctrl_if.sv
// Sample/config handshake bundle for delay_line_ctrl.
// The master side is the sample source and configuration agent.
interface delay_line_ctrl_if #(
  parameter int num_bits   = 16,
  parameter int max_cycles = 64
);
  localparam int DW = $clog2(max_cycles + 1);

  logic                cfg_valid;
  logic [DW-1:0]       cfg_delay;
  logic                cfg_ready;
  logic                in_valid;
  logic [num_bits-1:0] in_data;
  logic                in_ready;
  logic                out_valid;
  logic [num_bits-1:0] out_data;
  logic                busy;
  logic [DW-1:0]       current_delay;

  modport master (
    output cfg_valid, cfg_delay, in_valid, in_data,
    input  cfg_ready, in_ready, out_valid, out_data, busy, current_delay
  );

  modport slave (
    input  cfg_valid, cfg_delay, in_valid, in_data,
    output cfg_ready, in_ready, out_valid, out_data, busy, current_delay
  );
endinterface

// File: rtl/delay_line_ctrl.sv
// Run-time programmable sample delay built on a circular buffer.
// The buffer is flushed to initial_value after reset and on every delay change.
module delay_line_ctrl #(
  parameter int                  num_bits      = 16,
  parameter int                  max_cycles    = 64,
  parameter logic [num_bits-1:0] initial_value = '0
) (
  input  logic              clk,
  input  logic              reset,
  delay_line_ctrl_if.slave  bus
);
  localparam int DW = $clog2(max_cycles + 1);
  localparam int AW = (max_cycles > 1) ? $clog2(max_cycles) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state;
  logic [AW-1:0]       clear_cnt;
  logic [AW-1:0]       wptr;
  logic [DW-1:0]       cur_delay;
  logic                out_valid_q;
  logic [num_bits-1:0] out_data_q;
  logic                busy_q;
  logic                cfg_ready_q;

  logic [num_bits-1:0] mem [max_cycles];

  logic                accept;
  logic [DW:0]         rsum;
  logic [DW:0]         rwrap;
  logic [AW-1:0]       ridx;
  logic [DW-1:0]       clamped;

  assign bus.cfg_ready     = cfg_ready_q;
  assign bus.in_ready      = cfg_ready_q && !bus.cfg_valid;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.busy          = busy_q;
  assign bus.current_delay = cur_delay;

  assign accept  = bus.in_valid && bus.in_ready;
  assign clamped = (bus.cfg_delay > DW'(max_cycles)) ? DW'(max_cycles) : bus.cfg_delay;

  // Bias by max_cycles so the subtraction never underflows, then fold once;
  // works for any depth, not just powers of two.
  always_comb begin
    rsum  = (DW+1)'(wptr) + (DW+1)'(max_cycles) - {1'b0, cur_delay};
    rwrap = (rsum >= (DW+1)'(max_cycles)) ? rsum - (DW+1)'(max_cycles) : rsum;
    ridx  = rwrap[AW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CLEAR;
      clear_cnt   <= '0;
      wptr        <= '0;
      cur_delay   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= initial_value;
      busy_q      <= 1'b1;
      cfg_ready_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        CLEAR: begin
          if (clear_cnt == AW'(max_cycles - 1)) begin
            state       <= RUN;
            clear_cnt   <= '0;
            wptr        <= '0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
          end else begin
            clear_cnt <= clear_cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.cfg_valid) begin
            state       <= CLEAR;
            clear_cnt   <= '0;
            wptr        <= '0;
            cur_delay   <= clamped;
            busy_q      <= 1'b1;
            cfg_ready_q <= 1'b0;
          end else if (bus.in_valid) begin
            out_valid_q <= 1'b1;
            out_data_q  <= (cur_delay == '0) ? bus.in_data : mem[ridx];
            wptr        <= (wptr == AW'(max_cycles - 1)) ? '0 : wptr + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Read above is combinational, so a full-depth delay sees the old entry at wptr.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clear_cnt] <= initial_value;
    else if (accept)
      mem[wptr] <= bus.in_data;
  end
endmodule
